// File: rtl/hilo_muldiv_unit.sv
// HI/LO result register pair with an iterative shift-add multiplier and restoring divider.
// Optional macro HILO_SIGNED_EN enables signed MULT/DIV for op[0]=1; otherwise those ops run unsigned.
module hilo_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             write_lo,
    input  logic             write_hi,
    input  logic [WIDTH-1:0] value_lo,
    input  logic [WIDTH-1:0] value_hi,
    output logic [WIDTH-1:0] data_lo,
    output logic [WIDTH-1:0] data_hi,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               accept;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;

`ifdef HILO_SIGNED_EN
    assign a_neg    = op[0] & operand_a[WIDTH-1];
    assign b_neg    = op[0] & operand_b[WIDTH-1];
    assign a_mag_in = a_neg ? -operand_a : operand_a;
    assign b_mag_in = b_neg ? -operand_b : operand_b;
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign a_neg      = 1'b0;
    assign b_neg      = 1'b0;
    assign a_mag_in   = operand_a;
    assign b_mag_in   = operand_b;
`endif

    // FINISH also accepts a start so back-to-back operations lose no cycle.
    assign accept = start && (state == IDLE || state == FINISH);
    assign busy   = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FINISH;
            FINISH:  state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply: acc low half holds the multiplier, opnd the multiplicand.
    // Divide: acc = {remainder, dividend/quotient}, opnd the divisor.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rmd;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
        prod      = neg_res ? -acc : acc;
        quot      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd       = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            data_lo  <= '0;
            data_hi  <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_lo) data_lo <= value_lo;
                    if (write_hi) data_hi <= value_hi;
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= (count == LAST) ? '0 : count + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        {data_hi, data_lo} <= prod;
                    end else if (opnd == '0) begin
                        data_lo  <= '1;
                        data_hi  <= a_orig;
                        div_zero <= 1'b1;
                    end else begin
                        data_lo <= quot;
                        data_hi <= rmd;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                count   <= '0;
                is_div  <= op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                a_orig  <= operand_a;
                opnd    <= op[1] ? b_mag_in : a_mag_in;
                acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag_in : b_mag_in)};
            end
        end
    end
endmodule
